// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the multicycle controller: opcodes, ALU codes,
// datapath select encodings, FSM states and the opcode classifier.
package riscv_pkg;

   localparam int ALU_CONTROL_WIDTH = 4;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_PC4 = 2'b01;
   localparam logic [1:0] RES_MEM = 2'b10;

   localparam logic [1:0] SRCA_REG = 2'b00;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

   typedef enum logic [2:0] {
      CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_ILLEGAL
   } class_e;

   // Only word loads/stores are supported, so other widths classify as illegal.
   function automatic class_e classify(input logic [31:0] ins);
      case (ins[6:0])
         OP_R:      return CL_R;
         OP_I:      return CL_I;
         OP_LOAD:   return (ins[14:12] == 3'b010) ? CL_LOAD : CL_ILLEGAL;
         OP_STORE:  return (ins[14:12] == 3'b010) ? CL_STORE : CL_ILLEGAL;
         OP_BRANCH: return CL_BRANCH;
         OP_JAL:    return CL_JAL;
         OP_JALR:   return CL_JALR;
         default:   return CL_ILLEGAL;
      endcase
   endfunction

   function automatic logic [3:0] aluDecode(input logic [2:0] funct3,
                                            input logic funct7b5,
                                            input logic isR);
      case (funct3)
         3'b000:  return (isR && funct7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return funct7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control/handshake bundle between the multicycle controller (master) and the
// datapath plus instruction/data memories (slave).
interface mc_controller_if #(
   parameter int ALUcontrolWidth = riscv_pkg::ALU_CONTROL_WIDTH
);
   logic [31:0]                instr;
   logic                       zero;
   logic                       negative;
   logic                       overflow;
   logic                       carry;
   logic                       imemValid;
   logic                       dmemReady;
   logic                       regWrite;
   logic                       PCsrc;
   logic                       ALUsrcB;
   logic                       Jsrc;
   logic [ALUcontrolWidth-1:0] ALUcontrol;
   logic [1:0]                 immSrc;
   logic [1:0]                 resultSrc;
   logic [1:0]                 ALUsrcA;
   logic                       pcEn;
   logic                       instrEn;
   logic                       imemReq;
   logic                       dmemReq;
   logic                       dmemWe;
   logic                       halted;
   logic                       busErr;

   modport master (
      input  instr, zero, negative, overflow, carry, imemValid, dmemReady,
      output regWrite, PCsrc, ALUsrcB, Jsrc, ALUcontrol, immSrc, resultSrc,
             ALUsrcA, pcEn, instrEn, imemReq, dmemReq, dmemWe, halted, busErr
   );

   modport slave (
      output instr, zero, negative, overflow, carry, imemValid, dmemReady,
      input  regWrite, PCsrc, ALUsrcB, Jsrc, ALUcontrol, immSrc, resultSrc,
             ALUsrcA, pcEn, instrEn, imemReq, dmemReq, dmemWe, halted, busErr
   );
endinterface

// File: rtl/branch_unit.sv
// Branch condition evaluation from funct3 and ALU flags of a SUB compare.
// Combinational so it can be reused by a pipelined core.
module branch_unit (
   input  logic [2:0] i_funct3,
   input  logic       i_zero,
   input  logic       i_negative,
   input  logic       i_overflow,
   input  logic       i_carry,
   output logic       o_taken,
   output logic       o_illegal
);
   logic w_less;

   // carry=1 means the subtraction did not borrow, i.e. rs1 >= rs2 unsigned.
   assign w_less = i_negative ^ i_overflow;

   always_comb begin
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_funct3)
         3'b000:  o_taken = i_zero;
         3'b001:  o_taken = !i_zero;
         3'b100:  o_taken = w_less;
         3'b101:  o_taken = !w_less;
         3'b110:  o_taken = !i_carry;
         3'b111:  o_taken = i_carry;
         default: o_illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: FETCH, DECODE, EXEC, MEM, WB, HALT.
// Define MC_TIMEOUT_EN to halt with busErr when a memory stalls MEM_TIMEOUT cycles.
module mc_controller
   import riscv_pkg::*;
#(
   parameter int ALUcontrolWidth = ALU_CONTROL_WIDTH
`ifdef MC_TIMEOUT_EN
   , parameter int MEM_TIMEOUT = 16
`endif
) (
   input logic             clk,
   input logic             rst,
   mc_controller_if.master bus
);
   state_e r_state;
   class_e w_class;
   logic   w_taken;
   logic   w_branchIllegal;
   logic   w_isStore;
   logic   w_stall;
   logic   w_timeout;
   logic   w_busErr;
   logic   w_unused;

   assign w_class   = classify(bus.instr);
   assign w_isStore = (w_class == CL_STORE);
   assign w_stall   = ((r_state == FETCH) && !bus.imemValid) ||
                      ((r_state == MEM) && !bus.dmemReady);
   assign w_unused  = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

   branch_unit uBranch (
      .i_funct3   (bus.instr[14:12]),
      .i_zero     (bus.zero),
      .i_negative (bus.negative),
      .i_overflow (bus.overflow),
      .i_carry    (bus.carry),
      .o_taken    (w_taken),
      .o_illegal  (w_branchIllegal)
   );

`ifdef MC_TIMEOUT_EN
   localparam int CntWidth = $clog2(MEM_TIMEOUT + 1);
   logic [CntWidth-1:0] r_waitCnt;
   logic                r_busErr;

   // Any non-stall cycle precedes entry to FETCH/MEM, so clearing there restarts the count.
   assign w_timeout = w_stall && (r_waitCnt == CntWidth'(MEM_TIMEOUT - 1));
   assign w_busErr  = r_busErr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_waitCnt <= '0;
         r_busErr  <= 1'b0;
      end else begin
         r_waitCnt <= w_stall ? r_waitCnt + 1'b1 : '0;
         if (w_timeout) r_busErr <= 1'b1;
      end
   end
`else
   assign w_timeout = 1'b0;
   assign w_busErr  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= FETCH;
      end else begin
         case (r_state)
            FETCH:   if (bus.imemValid) r_state <= DECODE;
                     else if (w_timeout) r_state <= HALT;
            DECODE:  r_state <= (w_class == CL_ILLEGAL) ? HALT : EXEC;
            EXEC:    if (w_class == CL_LOAD || w_class == CL_STORE) r_state <= MEM;
                     else if (w_class == CL_BRANCH && w_branchIllegal) r_state <= HALT;
                     else r_state <= FETCH;
            MEM:     if (bus.dmemReady) r_state <= w_isStore ? FETCH : WB;
                     else if (w_timeout) r_state <= HALT;
            WB:      r_state <= FETCH;
            default: r_state <= HALT;
         endcase
      end
   end

   // Outputs are forced low during reset so an abandoned access never writes.
   always_comb begin
      bus.regWrite   = 1'b0;
      bus.PCsrc      = 1'b0;
      bus.ALUsrcB    = 1'b0;
      bus.Jsrc       = 1'b0;
      bus.ALUcontrol = '0;
      bus.immSrc     = IMM_I;
      bus.resultSrc  = RES_ALU;
      bus.ALUsrcA    = SRCA_REG;
      bus.pcEn       = 1'b0;
      bus.instrEn    = 1'b0;
      bus.imemReq    = 1'b0;
      bus.dmemReq    = 1'b0;
      bus.dmemWe     = 1'b0;
      bus.halted     = 1'b0;
      bus.busErr     = !rst && w_busErr;
      if (!rst) begin
         case (r_state)
            FETCH: begin
               bus.imemReq = 1'b1;
               bus.instrEn = bus.imemValid;
            end
            EXEC: begin
               case (w_class)
                  CL_R, CL_I: begin
                     bus.ALUsrcB    = (w_class == CL_I);
                     bus.ALUcontrol = ALUcontrolWidth'(aluDecode(bus.instr[14:12],
                                         bus.instr[30], w_class == CL_R));
                     bus.regWrite   = 1'b1;
                     bus.pcEn       = 1'b1;
                  end
                  CL_BRANCH: begin
                     bus.ALUcontrol = ALUcontrolWidth'(ALU_SUB);
                     bus.immSrc     = IMM_B;
                     bus.pcEn       = !w_branchIllegal;
                     bus.PCsrc      = w_taken && !w_branchIllegal;
                  end
                  CL_JAL, CL_JALR: begin
                     bus.immSrc    = (w_class == CL_JAL) ? IMM_J : IMM_I;
                     bus.Jsrc      = (w_class == CL_JALR);
                     bus.PCsrc     = 1'b1;
                     bus.pcEn      = 1'b1;
                     bus.regWrite  = 1'b1;
                     bus.resultSrc = RES_PC4;
                  end
                  CL_LOAD, CL_STORE: begin
                     bus.ALUsrcB    = 1'b1;
                     bus.ALUcontrol = ALUcontrolWidth'(ALU_ADD);
                     bus.immSrc     = w_isStore ? IMM_S : IMM_I;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               bus.ALUsrcB    = 1'b1;
               bus.ALUcontrol = ALUcontrolWidth'(ALU_ADD);
               bus.immSrc     = w_isStore ? IMM_S : IMM_I;
               bus.dmemReq    = 1'b1;
               bus.dmemWe     = w_isStore;
               bus.pcEn       = w_isStore && bus.dmemReady;
            end
            WB: begin
               bus.ALUsrcB    = 1'b1;
               bus.ALUcontrol = ALUcontrolWidth'(ALU_ADD);
               bus.regWrite   = 1'b1;
               bus.resultSrc  = RES_MEM;
               bus.pcEn       = 1'b1;
            end
            HALT:    bus.halted = 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: expected control bundles are queued per
// instruction and compared by a monitor on every pcEn (retire) cycle.
module tb_mc_controller;
   import riscv_pkg::*;

   typedef struct packed {
      logic       regWrite;
      logic       PCsrc;
      logic       Jsrc;
      logic       dmemWe;
      logic       ALUsrcB;
      logic [1:0] resultSrc;
      logic [1:0] immSrc;
      logic [3:0] aluCtl;
   } retire_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   int   cycleCnt, imemReqCnt, firstImemCycle, instrEnCnt, instrEnCycle;
   int   dmemReqCnt, dmemWeCnt, pcEnCnt, regWriteCnt, haltedCnt, strobeCnt, busErrCnt;
   retire_t sbQ[$];
   string   nameQ[$];

   mc_controller_if busIf ();

   mc_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (busIf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic retire_t mk(input logic rw, input logic pc, input logic js,
                                  input logic we, input logic sb, input logic [1:0] rs,
                                  input logic [1:0] is, input logic [3:0] alu);
      retire_t r;
      r = '{regWrite: rw, PCsrc: pc, Jsrc: js, dmemWe: we, ALUsrcB: sb,
            resultSrc: rs, immSrc: is, aluCtl: alu};
      return r;
   endfunction

   function automatic logic [31:0] allOutputs();
      return 32'({busIf.regWrite, busIf.PCsrc, busIf.ALUsrcB, busIf.Jsrc,
                  busIf.ALUcontrol, busIf.immSrc, busIf.resultSrc, busIf.ALUsrcA,
                  busIf.pcEn, busIf.instrEn, busIf.imemReq, busIf.dmemReq,
                  busIf.dmemWe, busIf.halted, busIf.busErr});
   endfunction

   // Monitor: per-cycle strobe statistics plus scoreboard compare on each retire.
   always @(negedge clk) begin
      retire_t act;
      retire_t exp;
      string   nm;
      cycleCnt++;
      if (busIf.imemReq) begin
         imemReqCnt++;
         if (firstImemCycle == 0) firstImemCycle = cycleCnt;
      end
      if (busIf.instrEn) begin
         instrEnCnt++;
         instrEnCycle = cycleCnt;
      end
      if (busIf.dmemReq)  dmemReqCnt++;
      if (busIf.dmemWe)   dmemWeCnt++;
      if (busIf.pcEn)     pcEnCnt++;
      if (busIf.regWrite) regWriteCnt++;
      if (busIf.halted)   haltedCnt++;
      if (busIf.busErr)   busErrCnt++;
      if (busIf.regWrite || busIf.pcEn || busIf.instrEn || busIf.imemReq ||
          busIf.dmemReq || busIf.dmemWe)
         strobeCnt++;
      if (busIf.pcEn) begin
         checks++;
         act = {busIf.regWrite, busIf.PCsrc, busIf.Jsrc, busIf.dmemWe, busIf.ALUsrcB,
                busIf.resultSrc, busIf.immSrc, busIf.ALUcontrol};
         if (sbQ.size() == 0) begin
            failures++;
            $display("[TB] FAIL retire-unexpected actual=%h required=no retire", act);
         end else begin
            exp = sbQ.pop_front();
            nm  = nameQ.pop_front();
            if (act !== exp) begin
               failures++;
               $display("[TB] FAIL retire-%s actual=%h required=%h", nm, act, exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearCounters();
      cycleCnt = 0; imemReqCnt = 0; firstImemCycle = 0; instrEnCnt = 0;
      instrEnCycle = 0; dmemReqCnt = 0; dmemWeCnt = 0; pcEnCnt = 0;
      regWriteCnt = 0; haltedCnt = 0; strobeCnt = 0; busErrCnt = 0;
   endtask

   task automatic checkOutput(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic expectRetire(input string nm, input retire_t r);
      sbQ.push_back(r);
      nameQ.push_back(nm);
   endtask

   // Drives one instruction from FETCH back to the next FETCH.
   task automatic applyStimulus(input logic [31:0] ins, input int fStall,
                                input int mStall, input logic [3:0] flags);
      busIf.instr = ins;
      {busIf.zero, busIf.negative, busIf.overflow, busIf.carry} = flags;
      busIf.imemValid = 1'b0;
      busIf.dmemReady = 1'b0;
      clearCounters();
      repeat (fStall) step();
      busIf.imemValid = 1'b1;
      step();
      busIf.imemValid = 1'b0;
      step();
      step();
      if (ins[6:0] == 7'b0000011 || ins[6:0] == 7'b0100011) begin
         repeat (mStall) step();
         busIf.dmemReady = 1'b1;
         step();
         busIf.dmemReady = 1'b0;
         if (ins[6:0] == 7'b0000011) step();
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      checks = 0;
      failures = 0;
      clearCounters();
      rst = 1'b1;
      busIf.instr = 32'h0;
      {busIf.zero, busIf.negative, busIf.overflow, busIf.carry} = 4'b0000;
      busIf.imemValid = 1'b0;
      busIf.dmemReady = 1'b0;
      step();
      busIf.imemValid = 1'b1;
      busIf.dmemReady = 1'b1;
      @(negedge clk);
      checkOutput("reset-outputs", allOutputs(), 32'h0);
      step();
      rst = 1'b0;

      $display("[TB] add x3,x1,x2 with two fetch stalls");
      expectRetire("add", mk(1, 0, 0, 0, 0, 2'b00, 2'b00, ALU_ADD));
      applyStimulus(32'h002081B3, 2, 0, 4'b0000);
      checkOutput("add-first-fetch-cycle", firstImemCycle, 1);
      checkOutput("add-instrEn-cycle", instrEnCycle, 3);
      checkOutput("add-imemReq-cycles", imemReqCnt, 3);
      checkOutput("add-total-cycles", cycleCnt, 5);
      checkOutput("add-pcEn-count", pcEnCnt, 1);
      checkOutput("add-regWrite-count", regWriteCnt, 1);

      $display("[TB] lw with three data stalls");
      expectRetire("lw", mk(1, 0, 0, 0, 1, 2'b10, 2'b00, ALU_ADD));
      applyStimulus(32'h0080A283, 0, 3, 4'b0000);
      checkOutput("lw-dmemReq-cycles", dmemReqCnt, 4);
      checkOutput("lw-dmemWe-cycles", dmemWeCnt, 0);
      checkOutput("lw-pcEn-count", pcEnCnt, 1);
      checkOutput("lw-regWrite-count", regWriteCnt, 1);
      checkOutput("lw-total-cycles", cycleCnt, 8);

      $display("[TB] sw with one data stall");
      expectRetire("sw", mk(0, 0, 0, 1, 1, 2'b00, 2'b01, ALU_ADD));
      applyStimulus(32'h0020A223, 0, 1, 4'b0000);
      checkOutput("sw-dmemWe-cycles", dmemWeCnt, 2);
      checkOutput("sw-regWrite-count", regWriteCnt, 0);
      checkOutput("sw-pcEn-count", pcEnCnt, 1);

      $display("[TB] branches");
      expectRetire("beq-zero", mk(0, 1, 0, 0, 0, 2'b00, 2'b10, ALU_SUB));
      applyStimulus(32'h00208463, 0, 0, 4'b1000);
      checkOutput("beq-regWrite-count", regWriteCnt, 0);
      expectRetire("bltu-carry", mk(0, 0, 0, 0, 0, 2'b00, 2'b10, ALU_SUB));
      applyStimulus(32'h0020E463, 0, 0, 4'b0001);
      expectRetire("bge-nv", mk(0, 1, 0, 0, 0, 2'b00, 2'b10, ALU_SUB));
      applyStimulus(32'h0020D463, 0, 0, 4'b0110);

      $display("[TB] jalr and ALU decode");
      expectRetire("jalr", mk(1, 1, 1, 0, 0, 2'b01, 2'b00, ALU_ADD));
      applyStimulus(32'h000280E7, 0, 0, 4'b0000);
      expectRetire("sub", mk(1, 0, 0, 0, 0, 2'b00, 2'b00, ALU_SUB));
      applyStimulus(32'h402081B3, 1, 0, 4'b0000);
      expectRetire("srai", mk(1, 0, 0, 0, 1, 2'b00, 2'b00, ALU_SRA));
      applyStimulus(32'h40315093, 0, 0, 4'b0000);
      expectRetire("addi-imm1024", mk(1, 0, 0, 0, 1, 2'b00, 2'b00, ALU_ADD));
      applyStimulus(32'h40000093, 0, 0, 4'b0000);

`ifdef MC_TIMEOUT_EN
      $display("[TB] lw with data memory never ready");
      busIf.instr = 32'h0080A283;
      busIf.dmemReady = 1'b0;
      busIf.imemValid = 1'b1;
      step();
      busIf.imemValid = 1'b0;
      step();
      step();
      clearCounters();
      for (int i = 0; i < 40 && !busIf.halted; i++) step();
      checkOutput("timeout-halted", busIf.halted, 1);
      checkOutput("timeout-busErr", busIf.busErr, 1);
      checkOutput("timeout-stall-cycles", dmemReqCnt, 16);
      checkOutput("timeout-no-pcEn", pcEnCnt, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
`else
      $display("[TB] lw with a long data stall");
      expectRetire("lw-long", mk(1, 0, 0, 0, 1, 2'b10, 2'b00, ALU_ADD));
      applyStimulus(32'h0080A283, 0, 30, 4'b0000);
      checkOutput("long-stall-busErr", busErrCnt, 0);
      checkOutput("long-stall-halted", haltedCnt, 0);
      checkOutput("long-stall-dmemReq", dmemReqCnt, 31);
`endif

      $display("[TB] reset during sw memory access");
      busIf.instr = 32'h0020A223;
      busIf.dmemReady = 1'b0;
      busIf.imemValid = 1'b1;
      step();
      busIf.imemValid = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      busIf.dmemReady = 1'b1;
      clearCounters();
      step();
      rst = 1'b0;
      busIf.dmemReady = 1'b0;
      step();
      checkOutput("rstmem-dmemReq", dmemReqCnt, 0);
      checkOutput("rstmem-pcEn", pcEnCnt, 0);
      checkOutput("rstmem-imemReq-after", imemReqCnt, 1);
      checkOutput("rstmem-first-fetch-cycle", firstImemCycle, 2);

      $display("[TB] unsupported opcode halts");
      busIf.instr = 32'h0000000F;
      busIf.imemValid = 1'b1;
      step();
      busIf.imemValid = 1'b0;
      step();
      clearCounters();
      repeat (20) step();
      checkOutput("halt-halted-cycles", haltedCnt, 20);
      checkOutput("halt-strobes", strobeCnt, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      expectRetire("add-after-halt", mk(1, 0, 0, 0, 0, 2'b00, 2'b00, ALU_ADD));
      applyStimulus(32'h002081B3, 0, 0, 4'b0000);
      checkOutput("recover-halted", haltedCnt, 0);
      checkOutput("recover-pcEn-count", pcEnCnt, 1);

      checkOutput("scoreboard-empty", sbQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
